video_stream_mon: RTL and testbench
===================================

VIDEO_STREAM_MON -- requirements
Module: video_stream_mon

Interface
REQ-001 SHALL have parameter DATAW, default 24, pixel data width in bits (multiple of 8).
REQ-002 SHALL have: clk  in  1  clock; all logic on rising edge.
REQ-003 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have: s_axis_tdata/tvalid/tready/tuser/tlast  in/in/out/in/in  DATAW/1/1/1/1  video stream from pattern generator; tuser=SOF, tlast=EOL.
REQ-005 SHALL have: m_axis_tdata/tvalid/tready/tuser/tlast  out/out/in/out/out  DATAW/1/1/1/1  forwarded stream to VDMA/video-out.
REQ-006 SHALL have: exp_width, exp_height  in  13 each  expected active pixels per line / lines per frame; quasi-static.
REQ-007 SHALL have: clr_err  in  1  one-cycle pulse clearing sticky error flags.
REQ-008 SHALL have: meas_width, meas_height  out  13 each  length of last completed line / line count of last completed frame.
REQ-009 SHALL have: frame_cnt  out  32  accepted SOF count since reset.
REQ-010 SHALL have: err_eol_early, err_eol_late, err_sof_early, err_sof_missing  out  1 each  sticky error flags.
REQ-011 SHALL have: locked  out  1  high after two consecutive error-free frames.

Function
REQ-012 Data path SHALL be a 2-entry skid buffer: registered s_axis_tready, m_axis_* registered, tdata/tuser/tlast forwarded unmodified, in order, no loss or duplication.
REQ-013 Latency SHALL be 1 cycle from accepted input beat to m_axis_tvalid when the output is empty; full throughput (1 beat/cycle) while m_axis_tready stays high.
REQ-014 s_axis_tready SHALL deassert only when both entries are full; m_axis_tvalid SHALL stay high and m_axis_* stable until m_axis_tready.
REQ-015 Monitor SHALL observe only accepted input beats (s_axis_tvalid && s_axis_tready); m_axis_tready backpressure SHALL NOT affect counts.
REQ-016 Monitor FSM states: IDLE (no SOF since reset), ACTIVE; IDLE -> ACTIVE on accepted tuser beat; no return to IDLE except reset.
REQ-017 In IDLE, beats without tuser SHALL be forwarded but not counted and raise no error.
REQ-018 Column counter x SHALL be set to 1 on a tuser beat, increment per beat, reset to 0 after a tlast beat; saturates at 8191.
REQ-019 On tlast beat: meas_width <= x+1 (saturated); err_eol_early if x+1 < exp_width; line counter y increments (saturating).
REQ-020 err_eol_late SHALL set on a non-tlast beat with x+1 == exp_width; counting continues.
REQ-021 On accepted tuser beat in ACTIVE: err_sof_early if y < exp_height or x != 0; meas_height <= y; y <= 0; frame_cnt increments (also on first SOF from IDLE, where meas_height is not updated).
REQ-022 In ACTIVE with y == exp_height and x == 0, a beat without tuser SHALL set err_sof_missing.
REQ-023 Beat with tuser and tlast together: treated as SOF then EOL of a 1-pixel line, same cycle.
REQ-024 Sticky flags cleared by clr_err; an error event in the same cycle as clr_err SHALL leave that flag set.
REQ-025 locked SHALL assert at the SOF ending the second consecutive frame with no error event, and deassert in the cycle after any error event.
REQ-026 frame_cnt SHALL wrap 0xFFFFFFFF -> 0.

Reset
REQ-027 While rst: s_axis_tready=0, m_axis_tvalid=0, buffer emptied, FSM=IDLE, x=y=0, meas_width=meas_height=0, frame_cnt=0, all err flags=0, locked=0.
REQ-028 s_axis_tready SHALL be 1 in the first cycle after rst deasserts; rst mid-frame discards buffered beats and restarts in IDLE.

Verification
REQ-029 exp 8x4, three clean 8x4 frames, m_axis_tready=1 -> output identical to input delayed 1 cycle, frame_cnt=3, meas_width=8, meas_height=4, locked=1, no errors.
REQ-030 Same stream, m_axis_tready random 50% -> no beat lost/duplicated/reordered, s_axis_tready low only with 2 entries held.
REQ-031 Line 2 with tlast on pixel 6 -> err_eol_early=1, meas_width=6, locked=0; clr_err -> flag 0.
REQ-032 Line with 10 pixels -> err_eol_late set at 8th pixel, meas_width=10 on tlast.
REQ-033 SOF after 2 lines -> err_sof_early=1, meas_height=2; frame of 5 lines -> err_sof_missing=1 on line-5 pixel 0.
REQ-034 rst asserted mid-line with buffer full -> next cycle m_axis_tvalid=0, frame_cnt=0; stream without SOF afterwards -> no errors, frame_cnt stays 0.

Source files
------------

// File: rtl/video_stream_mon.sv
// video_stream_mon
//   Pass-through monitor for a video stream (SOF on tuser, EOL on tlast).
//   A 2-entry skid buffer forwards every beat unmodified. Alongside it, a
//   monitor measures line length and frame height. It raises sticky
//   geometry error flags and reports lock once frames arrive clean.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   s_axis_*            input stream (tdata/tvalid/tready/tuser/tlast)
//   m_axis_*            forwarded stream, all outputs registered
//   exp_width/height    expected active pixels per line / lines per frame
//   clr_err             one-cycle pulse clearing the sticky error flags
//   meas_width/height   length of last completed line / lines of last frame
//   frame_cnt           accepted SOF beats since reset (wraps)
//   err_*               sticky error flags
//   locked              two consecutive error-free frames seen
module video_stream_mon #(
    parameter int DATAW = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DATAW-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tuser,
    input  logic             s_axis_tlast,
    output logic [DATAW-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tuser,
    output logic             m_axis_tlast,
    input  logic [12:0]      exp_width,
    input  logic [12:0]      exp_height,
    input  logic             clr_err,
    output logic [12:0]      meas_width,
    output logic [12:0]      meas_height,
    output logic [31:0]      frame_cnt,
    output logic             err_eol_early,
    output logic             err_eol_late,
    output logic             err_sof_early,
    output logic             err_sof_missing,
    output logic             locked
);

    localparam int          BW      = DATAW + 2;
    localparam logic [12:0] CNT_MAX = 13'h1FFF;

    typedef enum logic {IDLE, ACTIVE} state_t;

    // ------------------------------------------------------------------
    // Skid buffer: out_word is the output register. skid_word catches the
    // beat accepted while the output is stalled. Input ready is registered,
    // so it can only drop once both entries are occupied.
    // ------------------------------------------------------------------
    logic [BW-1:0] in_word, out_word, skid_word;
    logic          skid_valid, skid_valid_next, beat;

    assign beat    = s_axis_tvalid && s_axis_tready;
    assign in_word = {s_axis_tuser, s_axis_tlast, s_axis_tdata};
    assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = out_word;

    assign skid_valid_next = skid_valid ? !m_axis_tready
                                        : (m_axis_tvalid && !m_axis_tready && beat);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            skid_valid    <= 1'b0;
        end else begin
            s_axis_tready <= !skid_valid_next;
            skid_valid    <= skid_valid_next;
            // With the skid full the output stays valid until it refills from skid.
            if (!skid_valid && (!m_axis_tvalid || m_axis_tready))
                m_axis_tvalid <= beat;
        end
    end

    // NOTE: payload registers carry no reset; the valid bits above qualify
    // them, so clearing data would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (skid_valid) begin
            if (m_axis_tready)
                out_word <= skid_word;
        end else if (!m_axis_tvalid || m_axis_tready) begin
            if (beat)
                out_word <= in_word;
        end else if (beat) begin
            skid_word <= in_word;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: x = pixels seen so far in the current line, y = completed
    // lines in the current frame. A tuser beat restarts both before the beat
    // is counted, so tuser+tlast forms a 1-pixel line in one cycle.
    // ------------------------------------------------------------------
    state_t      state;
    logic [12:0] x, y, x_base, y_base, pix_cnt, line_cnt;
    logic        sof, mon_beat, frame_err, prev_clean;
    logic        ev_eol_early, ev_eol_late, ev_sof_early, ev_sof_missing, any_ev;

    assign sof      = beat && s_axis_tuser;
    assign mon_beat = beat && (state == ACTIVE || s_axis_tuser);
    assign x_base   = s_axis_tuser ? 13'd0 : x;
    assign y_base   = s_axis_tuser ? 13'd0 : y;
    assign pix_cnt  = (x_base == CNT_MAX) ? CNT_MAX : x_base + 13'd1;
    assign line_cnt = (y_base == CNT_MAX) ? CNT_MAX : y_base + 13'd1;

    assign ev_eol_early   = mon_beat && s_axis_tlast && (pix_cnt < exp_width);
    assign ev_eol_late    = mon_beat && !s_axis_tlast && (pix_cnt == exp_width);
    assign ev_sof_early   = sof && (state == ACTIVE) && ((y < exp_height) || (x != 13'd0));
    assign ev_sof_missing = beat && !s_axis_tuser && (state == ACTIVE)
                            && (y == exp_height) && (x == 13'd0);
    assign any_ev = ev_eol_early || ev_eol_late || ev_sof_early || ev_sof_missing;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            x               <= '0;
            y               <= '0;
            meas_width      <= '0;
            meas_height     <= '0;
            frame_cnt       <= '0;
            err_eol_early   <= 1'b0;
            err_eol_late    <= 1'b0;
            err_sof_early   <= 1'b0;
            err_sof_missing <= 1'b0;
            locked          <= 1'b0;
            frame_err       <= 1'b0;
            prev_clean      <= 1'b0;
        end else begin
            if (sof) begin
                state     <= ACTIVE;
                frame_cnt <= frame_cnt + 32'd1;
                if (state == ACTIVE) begin
                    meas_height <= y;
                    // The frame ending here is clean only if nothing went
                    // wrong in it, including a short frame flagged right now.
                    if (!frame_err && !ev_sof_early) begin
                        prev_clean <= 1'b1;
                        if (prev_clean)
                            locked <= 1'b1;
                    end else begin
                        prev_clean <= 1'b0;
                    end
                end
                // Line errors on the SOF beat belong to the new frame.
                frame_err <= ev_eol_early || ev_eol_late;
            end else if (any_ev) begin
                frame_err <= 1'b1;
            end

            if (any_ev)
                locked <= 1'b0;

            if (mon_beat) begin
                x <= s_axis_tlast ? 13'd0 : pix_cnt;
                y <= s_axis_tlast ? line_cnt : y_base;
                if (s_axis_tlast)
                    meas_width <= pix_cnt;
            end

            // A new event wins over a simultaneous clear.
            err_eol_early   <= ev_eol_early   || (err_eol_early   && !clr_err);
            err_eol_late    <= ev_eol_late    || (err_eol_late    && !clr_err);
            err_sof_early   <= ev_sof_early   || (err_sof_early   && !clr_err);
            err_sof_missing <= ev_sof_missing || (err_sof_missing && !clr_err);
        end
    end

endmodule

// File: tb/tb_video_stream_mon.sv
// tb_video_stream_mon
//   Self-checking bench for video_stream_mon. A scoreboard queue tracks
//   forwarded beats and buffer occupancy. Monitor results are predicted from
//   the frame geometry fed in, expressed as line lengths and lines per frame.
module tb_video_stream_mon;

    localparam int DATAW = 24;

    typedef struct packed {
        logic [DATAW-1:0] data;
        logic             user;
        logic             last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [DATAW-1:0] s_axis_tdata;
    logic             s_axis_tvalid, s_axis_tready, s_axis_tuser, s_axis_tlast;
    logic [DATAW-1:0] m_axis_tdata;
    logic             m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
    logic [12:0]      exp_width, exp_height, meas_width, meas_height;
    logic             clr_err;
    logic [31:0]      frame_cnt;
    logic             err_eol_early, err_eol_late, err_sof_early, err_sof_missing, locked;
    logic [3:0]       errs;

    assign errs = {err_eol_early, err_eol_late, err_sof_early, err_sof_missing};

    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;
    beat_t in_q[$];
    beat_t exp_q[$];
    bit    lat_chk, occ_chk, prev_acc;
    beat_t prev_b;

    video_stream_mon #(.DATAW(DATAW)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tlast   (s_axis_tlast),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tlast   (m_axis_tlast),
        .exp_width      (exp_width),
        .exp_height     (exp_height),
        .clr_err        (clr_err),
        .meas_width     (meas_width),
        .meas_height    (meas_height),
        .frame_cnt      (frame_cnt),
        .err_eol_early  (err_eol_early),
        .err_eol_late   (err_eol_late),
        .err_sof_early  (err_sof_early),
        .err_sof_missing(err_sof_missing),
        .locked         (locked)
    );

    // ---------------------------------------------------------------- helpers
    task automatic add_beat(input bit user, input bit last);
        beat_t b;
        b.data = DATAW'($urandom);
        b.user = user;
        b.last = last;
        in_q.push_back(b);
    endtask

    task automatic add_line(input int len, input bit sof);
        for (int i = 0; i < len; i++)
            add_beat(sof && (i == 0), i == len - 1);
    endtask

    task automatic add_frame(input int w, input int h);
        for (int l = 0; l < h; l++)
            add_line(w, l == 0);
    endtask

    task automatic drive_head;
        s_axis_tdata = in_q[0].data;
        s_axis_tuser = in_q[0].user;
        s_axis_tlast = in_q[0].last;
    endtask

    // One clock cycle: sample at the falling edge, score the beats that move
    // on the next rising edge, return 1 ns after that edge.
    task automatic step(output bit acc);
        bit    del;
        beat_t b, cur;
        @(negedge clk);
        cur.data = s_axis_tdata;
        cur.user = s_axis_tuser;
        cur.last = s_axis_tlast;
        acc = s_axis_tvalid && s_axis_tready;
        del = m_axis_tvalid && m_axis_tready;
        if (occ_chk) begin
            tests++;
            if (s_axis_tready !== (exp_q.size() < 2)) begin
                fails++;
                $display("FAIL occupancy: s_axis_tready=%b with %0d beats held", s_axis_tready, exp_q.size());
            end
        end
        if (lat_chk) begin
            tests++;
            if (m_axis_tvalid !== prev_acc ||
                (prev_acc && {m_axis_tdata, m_axis_tuser, m_axis_tlast} !== prev_b)) begin
                fails++;
                $display("FAIL latency: out valid=%b word=%h, want valid=%b word=%h",
                         m_axis_tvalid, {m_axis_tdata, m_axis_tuser, m_axis_tlast}, prev_acc, prev_b);
            end
        end
        if (del) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL extra_beat: got %h, want nothing", {m_axis_tdata, m_axis_tuser, m_axis_tlast});
            end else begin
                b = exp_q.pop_front();
                if ({m_axis_tdata, m_axis_tuser, m_axis_tlast} !== b) begin
                    fails++;
                    $display("FAIL beat_order: got %h, want %h", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, b);
                end
            end
        end
        if (acc)
            exp_q.push_back(cur);
        prev_acc = acc;
        prev_b   = cur;
        @(posedge clk);
        #1;
    endtask

    // Push every queued beat through the DUT and drain the output.
    task automatic send(input int gap_pct, input int rdy_pct, output int cycles);
        bit hold = 0;
        bit acc;
        cycles = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && cycles < 4000) begin
            if (!hold) begin
                s_axis_tvalid = (in_q.size() != 0) && ($urandom_range(99) >= gap_pct);
                if (s_axis_tvalid)
                    drive_head();
            end
            m_axis_tready = ($urandom_range(99) < rdy_pct);
            step(acc);
            if (acc)
                void'(in_q.pop_front());
            hold = s_axis_tvalid && !acc;
            cycles++;
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        tests++;
        if (in_q.size() != 0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d input and %0d output beats left, want 0", in_q.size(), exp_q.size());
        end
    endtask

    task automatic send_fast;
        int c;
        send(0, 100, c);
    endtask

    task automatic do_reset(input int w, input int h);
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        clr_err       = 1'b0;
        exp_width     = 13'(w);
        exp_height    = 13'(h);
        in_q.delete();
        exp_q.delete();
        prev_acc = 0;
        lat_chk  = 0;
        occ_chk  = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        occ_chk = 1;
    endtask

    task automatic pulse_clr;
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset;
        rst           = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = '1;
        s_axis_tuser  = 1'b1;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        clr_err       = 1'b0;
        exp_width     = 13'd8;
        exp_height    = 13'd4;
        occ_chk       = 0;
        lat_chk       = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL reset_handshake: tready=%b tvalid=%b, want 0 0", s_axis_tready, m_axis_tvalid);
        end
        tests++;
        if (frame_cnt !== 32'd0 || meas_width !== 13'd0 || meas_height !== 13'd0) begin
            fails++;
            $display("FAIL reset_counts: frame_cnt=%0d w=%0d h=%0d, want 0 0 0", frame_cnt, meas_width, meas_height);
        end
        tests++;
        if (errs !== 4'b0000 || locked !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: errs=%b locked=%b, want 0000 0", errs, locked);
        end
        @(posedge clk);
        #1;
        rst           = 1'b0;
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL ready_after_reset: tready=%b tvalid=%b, want 1 0", s_axis_tready, m_axis_tvalid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_clean_result(input string tag);
        tests++;
        if (frame_cnt !== 32'd3 || meas_width !== 13'd8 || meas_height !== 13'd4) begin
            fails++;
            $display("FAIL %s_meas: frame_cnt=%0d w=%0d h=%0d, want 3 8 4", tag, frame_cnt, meas_width, meas_height);
        end
        tests++;
        if (locked !== 1'b1 || errs !== 4'b0000) begin
            fails++;
            $display("FAIL %s_flags: locked=%b errs=%b, want 1 0000", tag, locked, errs);
        end
    endtask

    task automatic test_clean_frames;
        int cyc;
        do_reset(8, 4);
        repeat (3) add_frame(8, 4);
        lat_chk = 1;
        send(0, 100, cyc);
        lat_chk = 0;
        tests++;
        if (cyc !== 97) begin
            fails++;
            $display("FAIL throughput: %0d cycles for 96 beats, want 97", cyc);
        end
        check_clean_result("clean");
    endtask

    task automatic test_backpressure;
        int cyc;
        do_reset(8, 4);
        repeat (3) add_frame(8, 4);
        send(30, 50, cyc);
        check_clean_result("backpressure");
    endtask

    task automatic test_eol_early;
        bit acc;
        do_reset(8, 4);
        add_frame(8, 4);
        add_frame(8, 4);
        add_line(8, 1);
        send_fast();
        tests++;
        if (locked !== 1'b1) begin
            fails++;
            $display("FAIL lock_two_frames: locked=%b, want 1", locked);
        end
        add_line(6, 0);
        send_fast();
        tests++;
        if (errs !== 4'b1000 || meas_width !== 13'd6 || locked !== 1'b0) begin
            fails++;
            $display("FAIL eol_early: errs=%b w=%0d locked=%b, want 1000 6 0", errs, meas_width, locked);
        end
        pulse_clr();
        tests++;
        if (errs !== 4'b0000) begin
            fails++;
            $display("FAIL clr_err: errs=%b, want 0000", errs);
        end
        // Short line whose tlast arrives together with clr_err.
        add_line(4, 0);
        in_q[3].last = 1'b0;
        send_fast();
        add_beat(0, 1);
        s_axis_tvalid = 1'b1;
        drive_head();
        clr_err = 1'b1;
        step(acc);
        clr_err       = 1'b0;
        s_axis_tvalid = 1'b0;
        if (acc)
            void'(in_q.pop_front());
        send_fast();
        tests++;
        if (acc !== 1'b1 || err_eol_early !== 1'b1 || meas_width !== 13'd5) begin
            fails++;
            $display("FAIL clr_vs_event: acc=%b flag=%b w=%0d, want 1 1 5", acc, err_eol_early, meas_width);
        end
    endtask

    task automatic test_eol_late;
        do_reset(8, 4);
        add_line(8, 1);
        send_fast();
        for (int p = 1; p <= 10; p++) begin
            add_beat(0, p == 10);
            send_fast();
            tests++;
            if (err_eol_late !== (p >= 8)) begin
                fails++;
                $display("FAIL eol_late_px%0d: flag=%b, want %b", p, err_eol_late, p >= 8);
            end
        end
        tests++;
        if (meas_width !== 13'd10 || err_eol_early !== 1'b0) begin
            fails++;
            $display("FAIL eol_late_width: w=%0d early=%b, want 10 0", meas_width, err_eol_early);
        end
    endtask

    task automatic test_sof_errors;
        do_reset(8, 4);
        add_line(8, 1);
        add_line(8, 0);
        add_line(8, 1);
        send_fast();
        tests++;
        if (errs !== 4'b0010 || meas_height !== 13'd2 || frame_cnt !== 32'd2) begin
            fails++;
            $display("FAIL sof_early: errs=%b h=%0d frames=%0d, want 0010 2 2", errs, meas_height, frame_cnt);
        end
        pulse_clr();
        repeat (3) add_line(8, 0);
        send_fast();
        tests++;
        if (errs !== 4'b0000) begin
            fails++;
            $display("FAIL sof_missing_pre: errs=%b, want 0000", errs);
        end
        add_beat(0, 0);
        send_fast();
        tests++;
        if (errs !== 4'b0001) begin
            fails++;
            $display("FAIL sof_missing: errs=%b, want 0001", errs);
        end
    endtask

    task automatic test_sof_eol_beat;
        do_reset(8, 4);
        add_beat(1, 1);
        send_fast();
        tests++;
        if (meas_width !== 13'd1 || frame_cnt !== 32'd1 || errs !== 4'b1000) begin
            fails++;
            $display("FAIL sof_eol_first: w=%0d frames=%0d errs=%b, want 1 1 1000", meas_width, frame_cnt, errs);
        end
        add_beat(1, 1);
        send_fast();
        tests++;
        if (meas_height !== 13'd1 || frame_cnt !== 32'd2 || errs !== 4'b1010) begin
            fails++;
            $display("FAIL sof_eol_second: h=%0d frames=%0d errs=%b, want 1 2 1010", meas_height, frame_cnt, errs);
        end
    endtask

    task automatic test_rst_mid;
        bit acc;
        int cyc;
        do_reset(8, 4);
        add_line(8, 1);
        m_axis_tready = 1'b0;
        for (int i = 0; i < 10 && s_axis_tready; i++) begin
            s_axis_tvalid = 1'b1;
            drive_head();
            step(acc);
            if (acc)
                void'(in_q.pop_front());
        end
        tests++;
        if (s_axis_tready !== 1'b0 || exp_q.size() != 2) begin
            fails++;
            $display("FAIL fill_buffer: tready=%b held=%0d, want 0 2", s_axis_tready, exp_q.size());
        end
        occ_chk       = 0;
        s_axis_tvalid = 1'b0;
        rst           = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (m_axis_tvalid !== 1'b0 || frame_cnt !== 32'd0 || s_axis_tready !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid: tvalid=%b frames=%0d tready=%b, want 0 0 0", m_axis_tvalid, frame_cnt, s_axis_tready);
        end
        exp_q.delete();
        in_q.delete();
        prev_acc = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_axis_tready = 1'b1;
        @(posedge clk);
        #1;
        occ_chk = 1;
        add_line(8, 0);
        add_line(8, 0);
        send(20, 70, cyc);
        tests++;
        if (errs !== 4'b0000 || frame_cnt !== 32'd0 || meas_width !== 13'd0 || locked !== 1'b0) begin
            fails++;
            $display("FAIL idle_stream: errs=%b frames=%0d w=%0d locked=%b, want 0000 0 0 0",
                     errs, frame_cnt, meas_width, locked);
        end
    endtask

    // Random geometry: predict results from the list of line lengths per frame.
    task automatic test_random(input int iter);
        int w, h, nf, nl, len, r, cyc;
        int last_len, last_h, prev_lines, clean_run;
        bit e_early, e_late, e_sof_early, e_sof_missing, lines_ok, prev_lines_ok, want_lock;
        w  = $urandom_range(10, 2);
        h  = $urandom_range(5, 2);
        nf = $urandom_range(5, 3);
        do_reset(w, h);
        {e_early, e_late, e_sof_early, e_sof_missing} = 4'b0000;
        last_len = 0;  last_h = 0;  prev_lines = 0;  clean_run = 0;
        lines_ok = 1;  prev_lines_ok = 1;
        for (int f = 0; f < nf; f++) begin
            if (f > 0) begin
                if (prev_lines < h)
                    e_sof_early = 1;
                clean_run = (prev_lines_ok && prev_lines == h) ? clean_run + 1 : 0;
                last_h    = prev_lines;
            end
            nl = h + (($urandom_range(7) == 0) ? 1 : 0) - (($urandom_range(7) == 0) ? 1 : 0);
            lines_ok = 1;
            for (int l = 0; l < nl; l++) begin
                r   = $urandom_range(19);
                len = (r == 0) ? w - 1 : (r == 1) ? w + 1 : (r == 2) ? w + 2 : w;
                if (len < w) e_early = 1;
                if (len > w) e_late  = 1;
                if (len != w) lines_ok = 0;
                add_line(len, l == 0);
                last_len = len;
            end
            if (nl > h)
                e_sof_missing = 1;
            prev_lines    = nl;
            prev_lines_ok = lines_ok;
        end
        want_lock = (clean_run >= 2) && lines_ok && (nl <= h);
        send(25, 60, cyc);
        tests++;
        if (errs !== {e_early, e_late, e_sof_early, e_sof_missing}) begin
            fails++;
            $display("FAIL rand%0d_errs: errs=%b, want %b", iter, errs, {e_early, e_late, e_sof_early, e_sof_missing});
        end
        tests++;
        if (meas_width !== 13'(last_len) || meas_height !== 13'(last_h) || frame_cnt !== 32'(nf)) begin
            fails++;
            $display("FAIL rand%0d_meas: w=%0d h=%0d frames=%0d, want %0d %0d %0d",
                     iter, meas_width, meas_height, frame_cnt, last_len, last_h, nf);
        end
        tests++;
        if (locked !== want_lock) begin
            fails++;
            $display("FAIL rand%0d_lock: locked=%b, want %b", iter, locked, want_lock);
        end
    endtask

    initial begin
        test_reset();
        test_clean_frames();
        test_backpressure();
        test_eol_early();
        test_eol_late();
        test_sof_errors();
        test_sof_eol_beat();
        test_rst_mid();
        for (int i = 0; i < 6; i++)
            test_random(i);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
